// File: rtl/soft_start_ramp.sv
// -----------------------------------------------------------------------------
// soft_start_ramp
//
// Soft-start duty ramp for the SMPS PWM path. On a start request the commanded
// duty rises from 0 toward i_target_duty in increments of STEP. One increment
// is applied every STEP_PERIODS switching periods, and a switching period is
// TS_CYCLES clocks. The block then holds the settled duty and raises o_done.
//
// Parameters:
//   DUTY_W        duty width in bits
//   TS_CYCLES     clocks per switching period (>= 1)
//   STEP_PERIODS  switching periods per duty step (>= 1)
//   STEP          duty increment per step (>= 1, < 2**DUTY_W)
//
// Ports:
//   i_clk          system clock
//   reset          asynchronous active-high reset
//   i_enable       global enable; low freezes the ramp
//   i_start        single-cycle start request (IDLE only, needs i_enable)
//   i_abort        return to IDLE on the next edge; beats everything but reset
//   i_target_duty  final duty, sampled live
//   out_duty       registered commanded duty
//   o_enable       i_enable && (out_duty != 0)
//   o_busy         high while ramping
//   o_done         high once the target has been reached
//
// Build option:
//   SOFT_START_TRACK_EN  when defined, out_duty follows i_target_duty every
//                        clock in DONE. When undefined, out_duty holds the
//                        value written at completion.
// -----------------------------------------------------------------------------
module soft_start_ramp #(
    parameter int DUTY_W       = 10,
    parameter int TS_CYCLES    = 1000,
    parameter int STEP_PERIODS = 5,
    parameter int STEP         = 1
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              i_enable,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DUTY_W-1:0] i_target_duty,
    output logic [DUTY_W-1:0] out_duty,
    output logic              o_enable,
    output logic              o_busy,
    output logic              o_done
);

    localparam int PS_W = (TS_CYCLES > 1) ? $clog2(TS_CYCLES) : 1;
    localparam int PD_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(TS_CYCLES - 1);
    localparam logic [PD_W-1:0]   PD_LAST = PD_W'(STEP_PERIODS - 1);
    localparam logic [DUTY_W:0]   STEP_X  = (DUTY_W + 1)'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] w_duty_nx;
    logic [PS_W-1:0]   r_presc;
    logic [PS_W-1:0]   w_presc_nx;
    logic [PD_W-1:0]   r_period;
    logic [PD_W-1:0]   w_period_nx;

    logic              w_tick;
    logic              w_step;
    logic [DUTY_W:0]   w_sum;
    logic [DUTY_W-1:0] w_step_val;

    assign w_tick = (r_presc == PS_LAST);
    assign w_step = w_tick && (r_period == PD_LAST);

    // One extra bit so the increment can never wrap past the top code;
    // the result is then clipped to the target.
    assign w_sum      = {1'b0, r_duty} + STEP_X;
    assign w_step_val = (w_sum > {1'b0, i_target_duty}) ? i_target_duty
                                                        : w_sum[DUTY_W-1:0];

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_duty   <= '0;
            r_presc  <= '0;
            r_period <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_duty   <= w_duty_nx;
            r_presc  <= w_presc_nx;
            r_period <= w_period_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_duty_nx   = r_duty;
        w_presc_nx  = r_presc;
        w_period_nx = r_period;

        if (i_abort) begin
            w_state_nx  = ST_IDLE;
            w_duty_nx   = '0;
            w_presc_nx  = '0;
            w_period_nx = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_duty_nx   = '0;
                    w_presc_nx  = '0;
                    w_period_nx = '0;
                    if (i_start && i_enable) begin
                        // A zero target has nothing to ramp: finish at once.
                        w_state_nx = (i_target_duty == '0) ? ST_DONE : ST_RAMP;
                    end
                end

                ST_RAMP: begin
                    // With i_enable low, everything holds its value.
                    if (i_enable) begin
                        if (i_target_duty < r_duty) begin
                            // Target pulled below the present duty: clamp now
                            // instead of waiting for the next step.
                            w_duty_nx  = i_target_duty;
                            w_state_nx = ST_DONE;
                        end else begin
                            w_presc_nx = w_tick ? '0 : r_presc + PS_W'(1);
                            if (w_tick) begin
                                w_period_nx = (r_period == PD_LAST) ? '0
                                                                    : r_period + PD_W'(1);
                            end
                            if (w_step) begin
                                w_duty_nx = w_step_val;
                                if (w_step_val == i_target_duty) begin
                                    w_state_nx = ST_DONE;
                                end
                            end
                        end
                    end
                end

                ST_DONE: begin
`ifdef SOFT_START_TRACK_EN
                    w_duty_nx = i_target_duty;
`else
                    w_duty_nx = r_duty;
`endif
                end

                default: begin
                    w_state_nx  = ST_IDLE;
                    w_duty_nx   = '0;
                    w_presc_nx  = '0;
                    w_period_nx = '0;
                end
            endcase
        end
    end

    assign out_duty = r_duty;
    assign o_enable = i_enable && (r_duty != '0);
    assign o_busy   = (r_state == ST_RAMP);
    assign o_done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_soft_start_ramp.sv
module tb_soft_start_ramp;

    localparam int DW = 10;
    localparam int TS = 4;
    localparam int SP = 2;

    logic          i_clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_enable = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [DW-1:0] i_target_duty = '0;

    logic [DW-1:0] a_duty, b_duty;
    logic          a_oen, a_busy, a_done;
    logic          b_oen, b_busy, b_done;

    always #5 i_clk = ~i_clk;

    soft_start_ramp #(.DUTY_W(DW), .TS_CYCLES(TS), .STEP_PERIODS(SP), .STEP(1)) u_a (
        .i_clk(i_clk), .reset(reset), .i_enable(i_enable), .i_start(i_start),
        .i_abort(i_abort), .i_target_duty(i_target_duty),
        .out_duty(a_duty), .o_enable(a_oen), .o_busy(a_busy), .o_done(a_done));

    soft_start_ramp #(.DUTY_W(DW), .TS_CYCLES(TS), .STEP_PERIODS(SP), .STEP(4)) u_b (
        .i_clk(i_clk), .reset(reset), .i_enable(i_enable), .i_start(i_start),
        .i_abort(i_abort), .i_target_duty(i_target_duty),
        .out_duty(b_duty), .o_enable(b_oen), .o_busy(b_busy), .o_done(b_done));

    typedef struct {
        bit            use_b;
        logic [DW-1:0] duty;
        logic          busy;
        logic          done;
        logic          oen;
        string         name;
    } exp_t;

    typedef struct {
        logic          en;
        logic          st;
        logic          ab;
        logic [DW-1:0] tgt;
        logic [DW-1:0] duty;
        logic          busy;
        logic          done;
        logic          oen;
        string         name;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

`ifdef SOFT_START_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    function automatic exp_t mk(input bit b, input int duty, input logic busy,
                                input logic done, input logic oen, input string nm);
        exp_t e;
        e.use_b = b;
        e.duty  = DW'(duty);
        e.busy  = busy;
        e.done  = done;
        e.oen   = oen;
        e.name  = nm;
        return e;
    endfunction

    task automatic check_now(input exp_t e);
        logic [DW-1:0] d;
        logic          bz, dn, oe;
        d  = e.use_b ? b_duty : a_duty;
        bz = e.use_b ? b_busy : a_busy;
        dn = e.use_b ? b_done : a_done;
        oe = e.use_b ? b_oen  : a_oen;
        total++;
        if ({d, bz, dn, oe} !== {e.duty, e.busy, e.done, e.oen}) begin
            bad++;
            $display("FAIL %s: got duty=%0d busy=%b done=%b en=%b, want duty=%0d busy=%b done=%b en=%b",
                     e.name, d, bz, dn, oe, e.duty, e.busy, e.done, e.oen);
        end
    endtask

    // Drive one clock of stimulus; the expectation is queued as the stimulus
    // goes out and retired just after the edge that should produce it.
    task automatic cyc(input logic en, input logic st, input logic ab,
                       input logic [DW-1:0] tgt, input bit chk, input exp_t e);
        exp_t g;
        i_enable      = en;
        i_start       = st;
        i_abort       = ab;
        i_target_duty = tgt;
        if (chk) sb.push_back(e);
        @(posedge i_clk);
        #1;
        if (chk) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: got 0 entries, want 1");
            end else begin
                g = sb.pop_front();
                check_now(g);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        int   d;
        logic en;

        vt[0] = '{1'b0, 1'b1, 1'b0, 10'd5, 10'd0, 1'b0, 1'b0, 1'b0, "start_disabled"};
        vt[1] = '{1'b1, 1'b1, 1'b1, 10'd5, 10'd0, 1'b0, 1'b0, 1'b0, "start_with_abort"};
        vt[2] = '{1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, "start_zero_target"};
        vt[3] = '{1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, "zero_done_hold"};
        vt[4] = '{1'b1, 1'b0, 1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, "abort_from_done"};
        vt[5] = '{1'b1, 1'b1, 1'b0, 10'd5, 10'd0, 1'b1, 1'b0, 1'b0, "start_ok"};
        vt[6] = '{1'b1, 1'b1, 1'b0, 10'd5, 10'd0, 1'b1, 1'b0, 1'b0, "start_in_ramp"};
        vt[7] = '{1'b1, 1'b0, 1'b1, 10'd5, 10'd0, 1'b0, 1'b0, 1'b0, "abort_ramp"};

        // Reset state, before any clock edge.
        #2;
        check_now(mk(0, 0, 0, 0, 0, "reset_a"));
        check_now(mk(1, 0, 0, 0, 0, "reset_b"));
        @(posedge i_clk);
        #1;
        reset = 1'b0;

        // Short control sequences from IDLE.
        for (int i = 0; i < 8; i++) begin
            cyc(vt[i].en, vt[i].st, vt[i].ab, vt[i].tgt, 1'b1,
                mk(0, int'(vt[i].duty), vt[i].busy, vt[i].done, vt[i].oen, vt[i].name));
        end

        // Basic ramp to 3: steps every TS*SP = 8 edges after E0.
        cyc(1, 1, 0, 3, 1, mk(0, 0, 1, 0, 0, "ramp_e0"));
        for (int n = 1; n <= 24; n++) begin
            d = n / 8;
            cyc(1, 0, 0, 3, 1, mk(0, d, n < 24, n >= 24, d != 0, $sformatf("ramp_n%0d", n)));
        end

        // DONE: target moved to 7; start ignored; abort returns to IDLE.
        cyc(1, 0, 0, 7, 1, mk(0, TRACK ? 7 : 3, 0, 1, 1, "done_retarget"));
        cyc(1, 1, 0, 7, 1, mk(0, TRACK ? 7 : 3, 0, 1, 1, "start_in_done"));
        cyc(1, 0, 1, 7, 1, mk(0, 0, 0, 0, 0, "abort_done"));

        // Saturation on the STEP=4 instance: 4, 8, then clipped to 10.
        cyc(1, 1, 0, 10, 1, mk(1, 0, 1, 0, 0, "sat_e0"));
        for (int n = 1; n <= 25; n++) begin
            d = (n < 8) ? 0 : (n < 16) ? 4 : (n < 24) ? 8 : 10;
            cyc(1, 0, 0, 10, 1, mk(1, d, n < 24, n >= 24, d != 0, $sformatf("sat_n%0d", n)));
        end
        cyc(1, 0, 1, 10, 1, mk(1, 0, 0, 0, 0, "sat_abort"));

        // Pause: enable low on edges E0+3..E0+7 pushes step 1 to E0+13.
        cyc(1, 1, 0, 3, 1, mk(0, 0, 1, 0, 0, "pause_e0"));
        for (int n = 1; n <= 13; n++) begin
            en = !(n >= 3 && n <= 7);
            d  = (n >= 13) ? 1 : 0;
            cyc(en, 0, 0, 3, 1, mk(0, d, 1, 0, en && (d != 0), $sformatf("pause_n%0d", n)));
        end
        cyc(0, 0, 0, 3, 1, mk(0, 1, 1, 0, 0, "pause_oen_low"));
        cyc(1, 0, 1, 3, 1, mk(0, 0, 0, 0, 0, "pause_abort"));

        // Target drop from 20 to 3 while at duty 5.
        cyc(1, 1, 0, 20, 1, mk(0, 0, 1, 0, 0, "drop_e0"));
        for (int n = 1; n <= 40; n++) begin
            d = n / 8;
            cyc(1, 0, 0, 20, 1, mk(0, d, 1, 0, d != 0, $sformatf("drop_n%0d", n)));
        end
        cyc(1, 0, 0, 3, 1, mk(0, 3, 0, 1, 1, "drop_clamp"));
        cyc(1, 0, 1, 3, 1, mk(0, 0, 0, 0, 0, "drop_abort"));

        // Abort coinciding with the step that would write 3.
        cyc(1, 1, 0, 3, 1, mk(0, 0, 1, 0, 0, "abstep_e0"));
        for (int n = 1; n <= 23; n++) begin
            d = n / 8;
            cyc(1, 0, 0, 3, 1, mk(0, d, 1, 0, d != 0, $sformatf("abstep_n%0d", n)));
        end
        cyc(1, 0, 1, 3, 1, mk(0, 0, 0, 0, 0, "abort_on_step"));

        // Restart from 0 after the abort.
        cyc(1, 1, 0, 3, 1, mk(0, 0, 1, 0, 0, "restart_e0"));
        for (int n = 1; n <= 10; n++) begin
            d = n / 8;
            cyc(1, 0, 0, 3, 1, mk(0, d, 1, 0, d != 0, $sformatf("restart_n%0d", n)));
        end
        check_now(mk(1, 3, 0, 1, 1, "restart_b_done"));

        // Asynchronous reset mid-ramp, checked before the next clock edge.
        #2;
        reset = 1'b1;
        #1;
        check_now(mk(0, 0, 0, 0, 0, "async_reset_a"));
        check_now(mk(1, 0, 0, 0, 0, "async_reset_b"));
        reset = 1'b0;
        cyc(1, 0, 0, 3, 1, mk(0, 0, 0, 0, 0, "after_reset_idle"));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/soft_start_ramp.md
# soft_start_ramp

Soft-start ramp generator for the SMPS PWM path: on a start request it raises the commanded duty cycle from 0 to a target value in fixed steps, one step per programmable number of switching periods. It is the power-up counterpart of the soft-shutdown ramp-down. It sits between the duty-command source and the PWM generator, and hands the regulator a settled duty with a done flag.

## Interface
- DUTY_W, 10: duty-cycle width in bits.
- TS_CYCLES, 1000: clocks per switching period (prescaler terminal count); must be ≥1.
- STEP_PERIODS, 5: switching periods per duty step; must be ≥1.
- STEP, 1: duty increment per step; must be ≥1 and < 2^DUTY_W.
- Clock: one clock, `i_clk`.
- Reset: `reset` is asynchronous and active-high.
- i_clk  in  1  system clock.
- reset  in  1  async active-high reset.
- i_enable  in  1  global enable; low pauses the ramp.
- i_start  in  1  single-cycle start request, honoured only in IDLE with i_enable high.
- i_abort  in  1  immediate return to IDLE; has priority over everything except reset.
- i_target_duty  in  DUTY_W  final duty; sampled live.
- out_duty  out  DUTY_W  commanded duty, registered.
- o_enable  out  1  i_enable && (out_duty != 0), combinational.
- o_busy  out  1  high in RAMP.
- o_done  out  1  high in DONE.

## Operation
- States:
  - IDLE: out_duty = 0, counters cleared.
  - RAMP: ramp in progress.
  - DONE: target reached.
- IDLE → RAMP: on i_start && i_enable. If i_target_duty == 0 at that edge, go IDLE → DONE instead, with out_duty = 0.
- RAMP counters:
  - Prescaler counts 0..TS_CYCLES-1. A tick occurs when the count equals TS_CYCLES-1, and the count then wraps to 0.
  - Period counter advances on each tick over 0..STEP_PERIODS-1. A step occurs on a tick when the period counter equals STEP_PERIODS-1, and the counter then wraps.
- Step arithmetic:
  - sum = out_duty + STEP, computed at DUTY_W+1 bits with no wrap.
  - next = min(sum, i_target_duty).
  - out_duty ← next. If next == i_target_duty, the state goes to DONE on the same edge.
- Target lowered below out_duty during RAMP: on the next clock (not waiting for a step), out_duty ← i_target_duty and the state goes to DONE.
- Target raised during RAMP: the ramp simply continues toward the new value.
- i_enable low in RAMP: prescaler, period counter and out_duty freeze. Counting resumes from the frozen values when i_enable returns high. The state does not change.
- i_enable low in IDLE: i_start is ignored.
- i_abort, any state: the next edge sets the state to IDLE, out_duty to 0 and the counters to 0.
- i_start in RAMP or DONE: ignored.
- DONE → IDLE: only by i_abort or reset.

## Timing
- Reset values: state IDLE, out_duty 0, o_busy 0, o_done 0, counters 0. o_enable is then 0 because out_duty is 0.
- Define edge E0 as the edge that samples i_start. The state is RAMP after E0.
- Step k lands at edge E0 + k·TS_CYCLES·STEP_PERIODS, provided i_enable stays high.
- o_done rises on the same edge that writes the final out_duty.
- o_busy falls on that same edge.
- Abort and target-drop clamp: one-cycle latency.
- Simultaneous abort and step: abort wins.
- Simultaneous start and abort in IDLE: the block stays in IDLE.

## Configuration
- Macro: `SOFT_START_TRACK_EN`.
- Defined: in DONE, out_duty follows i_target_duty every clock with one-cycle latency, so the regulator can retune after soft start.
- Undefined: in DONE, out_duty holds the value written at completion and i_target_duty is ignored until the block returns to IDLE.

## Test plan
- Basic ramp. Setup: TS_CYCLES=4, STEP_PERIODS=2, STEP=1, target=3, i_start at E0. Required: out_duty = 1 at E0+8, 2 at E0+16, 3 at E0+24; o_done high at E0+24; o_busy high from E0+1 through E0+23.
- Saturation. Setup: STEP=4, target=10. Required: sequence 4, 8, 10; no overshoot; done asserted together with 10.
- Pause. Setup: basic ramp, i_enable low for 5 cycles starting E0+3. Required: first step moves to E0+13; o_enable low during the pause.
- Target drop. Setup: mid-ramp at out_duty=5, target changed from 20 to 3. Required: out_duty=3 and o_done high one cycle later.
- Abort. Setup: i_abort asserted at out_duty=2, together with a step edge. Required: next edge gives out_duty=0, IDLE, busy/done low; a later i_start restarts from 0.
- Configuration and corners:
  - DONE at 3, then target changed to 7. Required: out_duty=7 one cycle later with `SOFT_START_TRACK_EN` defined; stays 3 without it.
  - target=0 with i_start. Required: immediate DONE with out_duty=0.
  - Async reset mid-ramp. Required: all outputs 0 with no clock edge.
